// File: rtl/blink_pkg.sv
// Shared definitions for the LED blink controller.
//   blink_state_t : FSM state encoding (IDLE, ON, OFF, DONE)
//   PRESCALE_DEF  : default clock cycles per blink tick
//   CNT_W_DEF     : default width of the tick / repeat / cycle fields
package blink_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ON   = 2'd1,
    ST_OFF  = 2'd2,
    ST_DONE = 2'd3
  } blink_state_t;

  localparam int unsigned PRESCALE_DEF = 4;
  localparam int unsigned CNT_W_DEF    = 8;

endpackage

// File: rtl/blink_prescaler.sv
// Blink tick prescaler: free-running modulo-PRESCALE counter.
//   clk   : clock, rising edge
//   rst   : synchronous active-high reset
//   clear : forces the count back to 0 on the next edge
//   tick  : high on the cycle where the count equals PRESCALE-1
module blink_prescaler
  import blink_pkg::*;
#(
  parameter int unsigned PRESCALE = PRESCALE_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);

  // Keep at least one bit so PRESCALE=1 still elaborates; tick is then constant.
  localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [PW-1:0] count;

  assign tick = (count == PW'(PRESCALE - 1));

  always_ff @(posedge clk) begin
    if (rst || clear || tick) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/led_blink_controller.sv
// LED blink job controller.
// Accepts a job (ON ticks, OFF ticks, repeat count) through a valid/ready
// handshake and drives led_out through ON/OFF phases of N*PRESCALE cycles.
//   clk, rst   : clock and synchronous active-high reset
//   cfg_valid  : job offered;  cfg_ready : controller idle and able to accept
//   cfg_on     : ON ticks (0 treated as 1)
//   cfg_off    : OFF ticks (0 treated as 1)
//   cfg_repeat : ON/OFF cycles to run, 0 = run until stop
//   stop       : abort the running job (forces DONE)
//   led_out    : registered LED drive, 1 exactly while in ON
//   busy       : job in progress (ON, OFF, DONE)
//   done       : one-cycle pulse when a job ends
//   cycles     : completed ON/OFF cycles of the current or last job
// Build option: define BLINK_CYCLE_COUNT_EN to keep the cycle counter; when
// undefined, cycles reads 0 and termination uses a repeat down-counter.
module led_blink_controller
  import blink_pkg::*;
#(
  parameter int unsigned PRESCALE = PRESCALE_DEF,
  parameter int unsigned CNT_W    = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [CNT_W-1:0] cfg_on,
  input  logic [CNT_W-1:0] cfg_off,
  input  logic [CNT_W-1:0] cfg_repeat,
  input  logic             stop,
  output logic             led_out,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] cycles
);

  blink_state_t state, state_next;

  logic             tick;
  logic             pre_clear;
  logic             accept;
  logic             running;
  logic             phase_entry;
  logic             last_tick;
  logic             final_cycle;
  logic             led_next;
  logic [CNT_W-1:0] tick_cnt;
  logic [CNT_W-1:0] on_len;
  logic [CNT_W-1:0] off_len;
  logic [CNT_W-1:0] phase_len;
  logic [CNT_W-1:0] eff_len;

`ifdef BLINK_CYCLE_COUNT_EN
  logic [CNT_W-1:0] rep_len;
  logic [CNT_W-1:0] cycles_q;
`else
  logic [CNT_W-1:0] rep_left;
`endif

  blink_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .clk   (clk),
    .rst   (rst),
    .clear (pre_clear),
    .tick  (tick)
  );

  assign accept    = (state == ST_IDLE) && cfg_valid;
  assign running   = (state == ST_ON) || (state == ST_OFF);
  assign phase_len = (state == ST_ON) ? on_len : off_len;
  assign eff_len   = (phase_len == '0) ? CNT_W'(1) : phase_len;
  assign last_tick = tick && (tick_cnt == eff_len - 1'b1);

`ifdef BLINK_CYCLE_COUNT_EN
  assign final_cycle = (rep_len != '0) && (CNT_W'(cycles_q + 1'b1) == rep_len);
  assign cycles      = cycles_q;
`else
  // Down-counter reaching 1 on the final OFF phase matches cycles+1 == repeat.
  assign final_cycle = (rep_left == CNT_W'(1));
  assign cycles      = '0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      led_out <= 1'b0;
    end else begin
      state   <= state_next;
      led_out <= led_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (cfg_valid) state_next = ST_ON;
      ST_ON: begin
        if (stop)           state_next = ST_DONE;
        else if (last_tick) state_next = ST_OFF;
      end
      ST_OFF: begin
        if (stop)           state_next = ST_DONE;
        else if (last_tick) state_next = final_cycle ? ST_DONE : ST_ON;
      end
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase

    phase_entry = ((state_next == ST_ON) || (state_next == ST_OFF)) && (state_next != state);
    pre_clear   = phase_entry || !running;
    led_next    = (state_next == ST_ON);
    cfg_ready   = (state == ST_IDLE);
    busy        = (state != ST_IDLE);
    done        = (state == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tick_cnt <= '0;
      on_len   <= '0;
      off_len  <= '0;
`ifdef BLINK_CYCLE_COUNT_EN
      rep_len  <= '0;
      cycles_q <= '0;
`else
      rep_left <= '0;
`endif
    end else if (accept) begin
      tick_cnt <= '0;
      on_len   <= cfg_on;
      off_len  <= cfg_off;
`ifdef BLINK_CYCLE_COUNT_EN
      rep_len  <= cfg_repeat;
      cycles_q <= '0;
`else
      rep_left <= cfg_repeat;
`endif
    end else if (running && !stop) begin
      if (last_tick) begin
        tick_cnt <= '0;
        if (state == ST_OFF) begin
`ifdef BLINK_CYCLE_COUNT_EN
          cycles_q <= cycles_q + 1'b1;
`else
          if (rep_left != '0) rep_left <= rep_left - 1'b1;
`endif
        end
      end else if (tick) begin
        tick_cnt <= tick_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_led_blink_controller.sv
// Self-checking bench for led_blink_controller (PRESCALE=4, CNT_W=8).
// The reference model tracks a job as elapsed cycles since acceptance and
// derives led/busy/done/cycles from the ON/OFF period arithmetically.
module tb_led_blink_controller;

  localparam int P  = 4;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          cfg_valid;
  logic          cfg_ready;
  logic [CW-1:0] cfg_on;
  logic [CW-1:0] cfg_off;
  logic [CW-1:0] cfg_repeat;
  logic          stop;
  logic          led_out;
  logic          busy;
  logic          done;
  logic [CW-1:0] cycles;

  always #5 clk = ~clk;

  led_blink_controller #(
    .PRESCALE (P),
    .CNT_W    (CW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_on     (cfg_on),
    .cfg_off    (cfg_off),
    .cfg_repeat (cfg_repeat),
    .stop       (stop),
    .led_out    (led_out),
    .busy       (busy),
    .done       (done),
    .cycles     (cycles)
  );

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  typedef enum {M_IDLE, M_RUN, M_DONE} mmode_t;
  mmode_t m_mode = M_IDLE;
  int     m_t    = 0;
  int     m_onp  = P;
  int     m_per  = 2 * P;
  int     m_rep  = 0;
  int     m_cyc  = 0;

  task automatic check(input string tag, input int obs, input int exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_edge(input logic r, input logic v, input logic s,
                            input logic [CW-1:0] on, input logic [CW-1:0] off,
                            input logic [CW-1:0] rep);
    int on_n, off_n;
    if (r) begin
      m_mode = M_IDLE;
      m_cyc  = 0;
    end else begin
      case (m_mode)
        M_IDLE: if (v) begin
          on_n   = (on == 0) ? 1 : int'(on);
          off_n  = (off == 0) ? 1 : int'(off);
          m_mode = M_RUN;
          m_t    = 0;
          m_onp  = on_n * P;
          m_per  = (on_n + off_n) * P;
          m_rep  = int'(rep);
          m_cyc  = 0;
        end
        M_RUN: begin
          if (s) m_mode = M_DONE;
          else begin
            m_t++;
            m_cyc = (m_t / m_per) % 256;
            if (m_rep != 0 && m_t == m_rep * m_per) m_mode = M_DONE;
          end
        end
        default: m_mode = M_IDLE;
      endcase
    end
  endtask

  task automatic compare_all();
    int exp_led, exp_cyc;
    exp_led = (m_mode == M_RUN && (m_t % m_per) < m_onp) ? 1 : 0;
`ifdef BLINK_CYCLE_COUNT_EN
    exp_cyc = m_cyc;
`else
    exp_cyc = 0;
`endif
    check("led_out",   int'(led_out),   exp_led);
    check("busy",      int'(busy),      (m_mode != M_IDLE) ? 1 : 0);
    check("done",      int'(done),      (m_mode == M_DONE) ? 1 : 0);
    check("cfg_ready", int'(cfg_ready), (m_mode == M_IDLE) ? 1 : 0);
    check("cycles",    int'(cycles),    exp_cyc);
  endtask

  task automatic step(input logic r, input logic v, input logic s,
                      input logic [CW-1:0] on, input logic [CW-1:0] off,
                      input logic [CW-1:0] rep);
    @(negedge clk);
    rst        = r;
    cfg_valid  = v;
    stop       = s;
    cfg_on     = on;
    cfg_off    = off;
    cfg_repeat = rep;
    @(posedge clk);
    model_edge(r, v, s, on, off, rep);
    #1;
    compare_all();
  endtask

  task automatic nop(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, '0, '0, '0);
  endtask

  // Steps idle until done is seen; returns edge count (-1 if the bound expires).
  task automatic wait_done(input int limit, output int edges, output int leds);
    edges = -1;
    leds  = 0;
    for (int i = 1; i <= limit; i++) begin
      nop(1);
      leds += int'(led_out);
      if (done) begin
        edges = i;
        break;
      end
    end
  endtask

  int e, l;

  initial begin
    rst = 1'b1; cfg_valid = 1'b0; stop = 1'b0;
    cfg_on = '0; cfg_off = '0; cfg_repeat = '0;

    step(1'b1, 1'b0, 1'b0, '0, '0, '0);
    step(1'b1, 1'b1, 1'b1, 8'd5, 8'd5, 8'd5);
    nop(2);

    // on=2 off=3 repeat=2: done 40 edges after acceptance, 16 LED-on cycles.
    step(1'b0, 1'b1, 1'b0, 8'd2, 8'd3, 8'd2);
    l = int'(led_out);
    wait_done(100, e, l);
    check("job_2_3_2_done_edge", e, 40);
    check("job_2_3_2_led_cycles", l + 1, 16);
    nop(3);

    // on=0 off=0 repeat=1: zeros act as one tick.
    step(1'b0, 1'b1, 1'b0, 8'd0, 8'd0, 8'd1);
    wait_done(100, e, l);
    check("job_0_0_1_done_edge", e, 8);
    check("job_0_0_1_led_cycles", l + 1, 4);
    nop(2);

    // Endless job aborted by stop in an OFF phase.
    step(1'b0, 1'b1, 1'b0, 8'd3, 8'd3, 8'd0);
    nop(65);
    step(1'b0, 1'b0, 1'b1, '0, '0, '0);
    check("stop_forces_done", int'(done), 1);
    check("stop_led_low", int'(led_out), 0);
    nop(1);
    check("stop_then_idle", int'(busy), 0);

    // cfg_valid while busy is dropped; timing unchanged.
    step(1'b0, 1'b1, 1'b0, 8'd2, 8'd3, 8'd2);
    nop(5);
    step(1'b0, 1'b1, 1'b0, 8'd9, 8'd9, 8'd9);
    check("busy_ignores_valid", int'(cfg_ready), 0);
    wait_done(100, e, l);
    check("busy_valid_done_edge", e + 6, 40);
    nop(2);

    // Reset mid-job.
    step(1'b0, 1'b1, 1'b0, 8'd2, 8'd3, 8'd2);
    nop(4);
    step(1'b1, 1'b0, 1'b0, '0, '0, '0);
    check("rst_mid_ready", int'(cfg_ready), 1);
    nop(2);

    // stop alongside cfg_valid in IDLE still accepts.
    step(1'b0, 1'b1, 1'b1, 8'd1, 8'd1, 8'd3);
    check("idle_stop_accepts", int'(busy), 1);
    // stop wins over the ON->OFF phase end at edge 4.
    nop(3);
    step(1'b0, 1'b0, 1'b1, '0, '0, '0);
    nop(3);

    // Randomized traffic.
    for (int i = 0; i < 1500; i++) begin
      step($urandom_range(0, 199) == 0, $urandom_range(0, 3) == 0,
           $urandom_range(0, 29) == 0,
           CW'($urandom_range(0, 3)), CW'($urandom_range(0, 3)),
           CW'($urandom_range(0, 3)));
    end
    step(1'b1, 1'b0, 1'b0, '0, '0, '0);

    // Endless job long enough to wrap the cycle counter.
    step(1'b0, 1'b1, 1'b0, 8'd0, 8'd0, 8'd0);
    nop(2060);
    step(1'b0, 1'b0, 1'b1, '0, '0, '0);
    nop(2);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
